// File: rtl/pingpong_replay_memory.sv
// Two-bank record/replay row buffer: the writer fills one bank while the reader replays the other.
// Optional loop replay is compiled in with `define REPLAY_LOOP_EN.
module pingpong_replay_memory #(
  parameter int unsigned ROW       = 19,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned LOG_DEPTH = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [ROW-1:0] data_in,
  input  logic           commit,
  input  logic           rd_start,
  input  logic           rd_en,
  input  logic           rd_stop,
  input  logic           rd_loop,
  output logic [ROW-1:0] data_out,
  output logic           data_valid,
  output logic           data_last,
  output logic           rd_busy,
  output logic           wr_full,
  output logic           wr_ovf,
  output logic           commit_err
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StPlay = 1'b1;
  localparam logic [LOG_DEPTH:0] DepthCnt = DEPTH[LOG_DEPTH:0];

  logic [ROW-1:0] mem_q [2][DEPTH];

  logic [0:0]         state_q, state_d;
  logic               wr_bank_q, wr_bank_d;
  logic [LOG_DEPTH:0] wr_cnt_q, wr_cnt_d;
  logic [LOG_DEPTH:0] rd_len_q, rd_len_d;
  logic [LOG_DEPTH-1:0] rd_addr_q, rd_addr_d;
  logic               loop_q, loop_d;
  logic [ROW-1:0]     data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic               data_last_q, data_last_d;
  logic               wr_full_q, wr_full_d;
  logic               wr_ovf_q, wr_ovf_d;
  logic               commit_err_q, commit_err_d;

  logic               wr_fire;
  logic               at_last;
  logic               loop_sel;
  logic [LOG_DEPTH:0] cnt_after;

`ifdef REPLAY_LOOP_EN
  assign loop_sel = rd_loop;
`else
  logic unused_rd_loop;
  assign unused_rd_loop = rd_loop;
  assign loop_sel       = 1'b0;
`endif

  assign wr_fire   = we && (wr_cnt_q != DepthCnt);
  assign cnt_after = wr_cnt_q + {{LOG_DEPTH{1'b0}}, wr_fire};
  assign at_last   = ({1'b0, rd_addr_q} == (rd_len_q - 1'b1));

  always_comb begin
    state_d      = state_q;
    wr_bank_d    = wr_bank_q;
    wr_cnt_d     = cnt_after;
    rd_len_d     = rd_len_q;
    rd_addr_d    = rd_addr_q;
    loop_d       = loop_q;
    data_out_d   = '0;
    data_valid_d = 1'b0;
    data_last_d  = 1'b0;
    wr_ovf_d     = wr_ovf_q | (we & ~wr_fire);
    commit_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rd_start && (rd_len_q != '0) && !commit) begin
          state_d   = StPlay;
          rd_addr_d = '0;
          loop_d    = loop_sel;
        end
      end
      StPlay: begin
        // Stop wins over advance: no read happens in the stop cycle.
        if (rd_stop) begin
          state_d = StIdle;
        end else if (rd_en) begin
          data_valid_d = 1'b1;
          data_out_d   = mem_q[~wr_bank_q][rd_addr_q];
          data_last_d  = at_last;
          if (at_last) begin
            rd_addr_d = '0;
            if (!loop_q) state_d = StIdle;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // The read bank may only be swapped while nothing is replaying it.
    if (commit) begin
      if (state_q == StIdle) begin
        wr_bank_d = ~wr_bank_q;
        rd_len_d  = cnt_after;
        wr_cnt_d  = '0;
        wr_ovf_d  = 1'b0;
      end else begin
        commit_err_d = 1'b1;
      end
    end

    wr_full_d = (wr_cnt_d == DepthCnt);
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_bank_q][wr_cnt_q[LOG_DEPTH-1:0]] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_bank_q    <= 1'b0;
      wr_cnt_q     <= '0;
      rd_len_q     <= '0;
      rd_addr_q    <= '0;
      loop_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      data_last_q  <= 1'b0;
      wr_full_q    <= 1'b0;
      wr_ovf_q     <= 1'b0;
      commit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_bank_q    <= wr_bank_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_len_q     <= rd_len_d;
      rd_addr_q    <= rd_addr_d;
      loop_q       <= loop_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      data_last_q  <= data_last_d;
      wr_full_q    <= wr_full_d;
      wr_ovf_q     <= wr_ovf_d;
      commit_err_q <= commit_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign data_last  = data_last_q;
  assign rd_busy    = (state_q == StPlay);
  assign wr_full    = wr_full_q;
  assign wr_ovf     = wr_ovf_q;
  assign commit_err = commit_err_q;

endmodule

// File: tb/tb_pingpong_replay_memory.sv
// Bench for pingpong_replay_memory: directed scenarios plus random traffic, checked every cycle
// against a frame-queue reference model. Honours `define REPLAY_LOOP_EN like the design.
module tb_pingpong_replay_memory;

  localparam int unsigned ROW       = 19;
  localparam int unsigned DEPTH     = 128;
  localparam int unsigned LOG_DEPTH = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, we, commit, rd_start, rd_en, rd_stop, rd_loop;
  logic [ROW-1:0] data_in;
  logic [ROW-1:0] data_out;
  logic           data_valid, data_last, rd_busy, wr_full, wr_ovf, commit_err;

  pingpong_replay_memory #(
    .ROW      (ROW),
    .DEPTH    (DEPTH),
    .LOG_DEPTH(LOG_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .data_in   (data_in),
    .commit    (commit),
    .rd_start  (rd_start),
    .rd_en     (rd_en),
    .rd_stop   (rd_stop),
    .rd_loop   (rd_loop),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_last (data_last),
    .rd_busy   (rd_busy),
    .wr_full   (wr_full),
    .wr_ovf    (wr_ovf),
    .commit_err(commit_err)
  );

  // Reference model: the frame being recorded and the committed frame, as plain queues.
  logic [ROW-1:0] wq[$];
  logic [ROW-1:0] rf[$];
  bit             m_play, m_loop, m_ovf;
  int             m_pos;
  int             n_vec = 0;
  int             n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic set_idle();
    rst = 0; we = 0; commit = 0; rd_start = 0; rd_en = 0; rd_stop = 0; rd_loop = 0;
    data_in = '0;
  endtask

  // Advance one clock with the currently driven inputs and check every output.
  task automatic cyc();
    logic [ROW-1:0] e_out;
    logic           e_v, e_l, e_cerr;
    bit             was_play;
    int             len;
    e_out = '0; e_v = 0; e_l = 0; e_cerr = 0;
    if (rst) begin
      wq.delete(); rf.delete();
      m_play = 0; m_pos = 0; m_loop = 0; m_ovf = 0;
    end else begin
      was_play = m_play;
      len      = rf.size();
      if (!m_play) begin
        if (rd_start && len != 0 && !commit) begin
          m_play = 1;
          m_pos  = 0;
`ifdef REPLAY_LOOP_EN
          m_loop = rd_loop;
`else
          m_loop = 0;
`endif
        end
      end else if (rd_stop) begin
        m_play = 0;
      end else if (rd_en) begin
        e_v   = 1;
        e_out = rf[m_pos];
        e_l   = (m_pos == len - 1);
        if (e_l) begin
          m_pos = 0;
          if (!m_loop) m_play = 0;
        end else begin
          m_pos++;
        end
      end
      if (we) begin
        if (wq.size() < DEPTH) wq.push_back(data_in);
        else m_ovf = 1;
      end
      if (commit) begin
        if (!was_play) begin
          rf = wq;
          wq.delete();
          m_ovf = 0;
        end else begin
          e_cerr = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("data_out",   32'(data_out),   32'(e_out));
    chk("data_valid", 32'(data_valid), 32'(e_v));
    chk("data_last",  32'(data_last),  32'(e_l));
    chk("rd_busy",    32'(rd_busy),    32'(m_play));
    chk("wr_full",    32'(wr_full),    32'(wq.size() == DEPTH));
    chk("wr_ovf",     32'(wr_ovf),     32'(m_ovf));
    chk("commit_err", 32'(commit_err), 32'(e_cerr));
  endtask

  task automatic write_words(input int n, input bit counting);
    for (int i = 0; i < n; i++) begin
      we      = 1;
      data_in = counting ? ROW'(i + 1) : ROW'($urandom);
      cyc();
    end
    we = 0;
  endtask

  task automatic do_commit();
    commit = 1;
    cyc();
    commit = 0;
  endtask

  initial begin
    set_idle();
    // Reset state
    rst = 1;
    cyc(); cyc();
    rst = 0;

    // Basic 5-word frame 1..5
    write_words(5, 1);
    do_commit();
    rd_start = 1; rd_en = 1;
    cyc();
    rd_start = 0;
    repeat (7) cyc();
    rd_en = 0;

    // Overflow: DEPTH+2 writes, replay exactly DEPTH words
    write_words(DEPTH + 2, 0);
    do_commit();
    rd_start = 1; rd_en = 1;
    cyc();
    rd_start = 0;
    repeat (DEPTH + 2) cyc();
    rd_en = 0;

    // Frame A replays while frame B is recorded; mid-replay commit is rejected
    write_words(4, 0);
    do_commit();
    rd_start = 1; rd_en = 1;
    cyc();
    rd_start = 0;
    for (int i = 0; i < 4; i++) begin
      we      = (i < 3);
      data_in = ROW'($urandom);
      commit  = (i == 1);
      cyc();
    end
    we = 0; commit = 0;
    repeat (2) cyc();
    do_commit();
    rd_start = 1;
    cyc();
    rd_start = 0;
    repeat (4) cyc();
    rd_en = 0;

    // Pause for two cycles, then stop mid-frame
    write_words(6, 0);
    do_commit();
    rd_start = 1;
    cyc();
    rd_start = 0;
    for (int i = 0; i < 9; i++) begin
      rd_en   = !(i == 2 || i == 3);
      rd_stop = (i == 6);
      cyc();
    end
    rd_en = 0; rd_stop = 0;

    // rd_start in the same cycle as commit is ignored; empty commit gives rd_len=0
    write_words(2, 0);
    commit = 1; rd_start = 1; rd_en = 1;
    cyc();
    commit = 0; rd_start = 0;
    repeat (2) cyc();
    do_commit();
    rd_start = 1;
    cyc();
    rd_start = 0;
    repeat (2) cyc();
    rd_en = 0;

    // Loop mode on a 3-word frame until stopped
    write_words(3, 1);
    do_commit();
    rd_loop = 1; rd_start = 1; rd_en = 1;
    cyc();
    rd_start = 0; rd_loop = 0;
    repeat (7) cyc();
    rd_stop = 1;
    cyc();
    rd_stop = 0;
    repeat (2) cyc();
    rd_en = 0;

    // Reset during replay, then rd_start has nothing to play
    write_words(4, 0);
    do_commit();
    rd_start = 1; rd_en = 1;
    cyc();
    rd_start = 0;
    repeat (2) cyc();
    rst = 1;
    cyc();
    rst = 0; rd_start = 1;
    cyc();
    rd_start = 0;
    repeat (2) cyc();
    rd_en = 0;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      we       = ($urandom_range(0, 2) != 0);
      data_in  = ROW'($urandom);
      commit   = ($urandom_range(0, 15) == 0);
      rd_start = ($urandom_range(0, 5) == 0);
      rd_en    = ($urandom_range(0, 3) != 0);
      rd_stop  = ($urandom_range(0, 40) == 0);
      rd_loop  = ($urandom_range(0, 1) != 0);
      cyc();
    end
    set_idle();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pingpong_replay_memory.md
Name: pingpong_replay_memory

Overview:
- Successor to the single-bank record/replay row buffer, generalised to two ping-pong banks.
- The writer records a frame into one bank while the reader replays the previously committed frame from the other bank.
- Replay length tracks the recorded count instead of the full depth.
- Supports pause, abort and an optional loop mode.
- Sits between the row producer and the downstream row consumer.

Parameters:
- ROW, 19, word width in bits
- DEPTH, 128, words per bank
- LOG_DEPTH, 7, address width, ceil(log2(DEPTH))

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- we  input  1  write strobe for the current write bank
- data_in  input  ROW  write data
- commit  input  1  pulse: close current frame and swap banks
- rd_start  input  1  pulse: begin replay of committed frame
- rd_en  input  1  replay advance enable (0 = pause)
- rd_stop  input  1  pulse: abort replay
- rd_loop  input  1  loop mode select, sampled at rd_start
- data_out  output  ROW  replay data, 0 when data_valid=0
- data_valid  output  1  data_out holds a replayed word
- data_last  output  1  qualifies last word of the frame (with data_valid)
- rd_busy  output  1  reader FSM not IDLE
- wr_full  output  1  write bank holds DEPTH words
- wr_ovf  output  1  sticky: a write was dropped because the bank was full
- commit_err  output  1  one-cycle pulse: commit rejected

Behaviour:
- Reset (rst=1 at posedge):
  - Outputs: data_out, data_valid, data_last, rd_busy, wr_full, wr_ovf and commit_err all 0.
  - Internal: wr_bank=0, wr_cnt=0, rd_len=0, rd_addr=0, FSM=IDLE.
  - Memory contents are not cleared.
  - Reset mid-replay or mid-write aborts immediately; the frame is lost.
- Storage: two arrays of DEPTH x ROW. The write bank is wr_bank; the read bank is ~wr_bank.
- Write path:
  - If we=1 and wr_cnt<DEPTH: mem[wr_bank][wr_cnt]<=data_in and wr_cnt increments.
  - If we=1 and wr_cnt==DEPTH: the write is dropped and wr_ovf<=1.
  - wr_full = (wr_cnt==DEPTH), registered.
  - wr_cnt is LOG_DEPTH+1 bits wide, so DEPTH is representable.
- Commit:
  - Accepted only when FSM=IDLE. On acceptance: wr_bank toggles, rd_len<=wr_cnt (including a write accepted in the same cycle), wr_cnt<=0, wr_ovf<=0.
  - If FSM!=IDLE: no swap, the write bank keeps its contents, and commit_err pulses for 1 cycle on the next cycle.
  - A commit with wr_cnt=0 is legal and gives rd_len=0.
- Reader FSM, states IDLE and PLAY:
  - IDLE -> PLAY on rd_start when rd_len!=0 and commit=0 the same cycle. This sets rd_addr<=0 and latches loop_q<=rd_loop.
  - rd_start with rd_len=0, or in the same cycle as commit, is ignored.
  - In PLAY with rd_en=1, read mem[~wr_bank][rd_addr]:
    - data_out and data_valid are registered, 1-cycle latency.
    - data_last=1 when rd_addr==rd_len-1.
    - rd_addr increments, except at rd_len-1: if loop_q, rd_addr<=0 and stay in PLAY; otherwise go to IDLE.
  - In PLAY with rd_en=0: pause, rd_addr holds, and data_valid, data_last and data_out go to 0 next cycle.
  - rd_stop in PLAY -> IDLE. No read occurs that cycle, even if rd_en=1. rd_stop has priority over rd_en.
  - rd_start while in PLAY is ignored.
- rd_busy = (FSM==PLAY), registered with the state.
- Writing during PLAY is always permitted; the banks are disjoint.

Optional Feature:
- Macro: REPLAY_LOOP_EN.
- Defined: loop mode as above, with rd_loop latched at rd_start.
- Undefined: the rd_loop port remains but is ignored, loop_q is tied to 0, and every replay ends after rd_len words.

Test Plan:
- Write 5 words 0x1..0x5, commit, rd_start, rd_en=1 -> data_out 0x1..0x5 on the 5 cycles after the first read, data_last with 0x5, then rd_busy=0 and data_valid=0.
- Write DEPTH+2 words -> wr_full=1 after word DEPTH, wr_ovf=1, and after commit the replay yields exactly DEPTH words with wr_ovf cleared.
- During replay of frame A (4 words), write frame B (3 words) and commit mid-replay -> commit_err pulses and A completes unchanged. Commit again after IDLE -> replay yields B's 3 words.
- Replay 6 words with rd_en deasserted for 2 cycles after word 2 -> data_valid=0 for 2 cycles, then word 3 continues. rd_stop after word 4 -> no further valid words.
- With REPLAY_LOOP_EN, rd_loop=1, frame of 3 -> sequence 1,2,3,1,2,3 with data_last on each 3 until rd_stop. Without REPLAY_LOOP_EN -> single pass only.
- Assert rst during PLAY -> next cycle all outputs 0. rd_start afterwards is ignored (rd_len=0).
